fmt_decode_q: RTL and testbench
===============================

// Module: fmt_decode_q
// PURPOSE
//  Registered, buffered successor to the combinational format decoder. Accepts fetched
//  instruction words over a valid/ready handshake and classifies each by opcode into
//  J/I1/I2/R/SP/IL. Also extracts the register and sign-extended immediate fields.
//  Results are queued in a DEPTH-entry FIFO feeding the execute stage, with flush
//  support and a saturating illegal-opcode counter for debug.
// PARAMETERS
//  INSTR_W  16  instruction word width; opcode = instr[INSTR_W-1 -: OP_W]
//  OP_W     5   opcode width; table below defined for OP_W=5, upper bits beyond 5 must be 0 else IL
//  DEPTH    2   FIFO entries; power of two, >=2
//  CNT_W    8   width of illegal-opcode counter
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        synchronous reset, active low
//  flush      in   1        discard all queued entries (branch redirect)
//  in_valid   in   1        instr valid
//  in_ready   out  1        block can accept instr this cycle
//  instr      in   INSTR_W  instruction word
//  out_valid  out  1        head entry valid
//  out_ready  in   1        consumer takes head this cycle
//  out_fmt    out  3        format code of head
//  out_instr  out  INSTR_W  raw instr of head
//  out_rs     out  3        instr[10:8]
//  out_rt     out  3        instr[7:5]
//  out_rd     out  3        instr[4:2]
//  out_imm    out  INSTR_W  sign-extended immediate selected by fmt
//  out_ill    out  1        head fmt == IL
//  ill_cnt    out  CNT_W    saturating count of IL instrs accepted
// BEHAVIOUR
//  Reset (rst_n=0 at edge): FIFO empty, out_valid=0, in_ready=1, ill_cnt=0, all out_* data = 0.
//  Format codes: J=0 I1=1 I2=2 R=3 SP=4 IL=7. Decode priority, first match wins:
//   000xx SP | 001x0 J | 011xx I2 | 001x1 I2 | 11000 I2 | 10010 I2 | 010xx I1 |
//   101xx I1 | 1000x I1 | 10011 I1 | 11xxx R | else IL (in practice only 10001 now covered as I1)
//  Immediate: I1 -> sext(instr[4:0]); I2 -> sext(instr[7:0]); J -> sext(instr[10:0]);
//   R/SP/IL -> 0. Decode and field extraction happen at push; FIFO stores decoded entry.
//  Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready & ~flush.
//  in_ready = (count != DEPTH) from registered state only; no comb path from out_ready.
//  out_valid = (count != 0); out_* driven from head entry (registered, no comb from instr).
//  Latency: push at edge N -> out_valid=1 with that entry after edge N (visible cycle N+1).
//  Throughput: 1/cycle sustained when out_ready held high.
//  Simultaneous push+pop when 0<count<DEPTH: count unchanged, head advances, tail written.
//  Full: in_ready=0, in_valid ignored; pop frees a slot visible next cycle.
//  Empty: out_ready ignored; out_* hold last values (don't-care while out_valid=0).
//  Flush: next cycle count=0, pointers reset, out_valid=0; push and pop same cycle are dropped.
//  ill_cnt: +1 on each push with fmt=IL; saturates at 2^CNT_W-1; unaffected by flush.
//  Pointers: log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
//  Reset mid-stream overrides flush, push, and pop.
// STRUCTURE
//  fmt_pkg.vh: localparams FMT_J/I1/I2/R/SP/IL, FMT_W=3, opcode position macros.
//  Sub-module fmt_lut: pure combinational opcode->fmt table (casex as above) plus imm select.
//  Top: FIFO storage array, rd/wr pointers, count, ill_cnt saturating counter.
// TESTING
//  1 Reset then push 16'h4000 (op 01000), out_ready=1 -> cycle+1 out_valid=1,
//    out_fmt=1 (I1), out_imm=0.
//  2 Sweep all 32 opcodes back-to-back, out_ready=1 -> one result per cycle in order;
//    fmt matches table; 10001->1; ill_cnt stays 0.
//  3 out_ready=0, push 3 instrs at DEPTH=2 -> in_ready=0 after 2nd; 3rd held by source.
//    Release -> order A, B, C preserved.
//  4 Push 16'h27FF (op 00100 J) -> out_imm=16'hFFFF. Push 16'h4810 (I1 imm 10000) ->
//    out_imm=16'hFFF0.
//  5 Queue 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, count=0,
//    flushed-cycle instr not queued.
//  6 Force IL (OP_W=6, opcode 6'h20) 300 times with CNT_W=8 -> ill_cnt=255, out_ill=1 each.

Source files
------------

// File: rtl/fmt_decode_q_pkg.sv
// ============================================================================
//  Module      : fmt_decode_q_pkg
//  Description : Format codes and instruction field positions shared by the
//                queued format decoder and its opcode lookup table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fmt_decode_q_pkg;

    localparam int FMT_W = 3;

    localparam logic [FMT_W-1:0] FMT_J  = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I1 = 3'd1;
    localparam logic [FMT_W-1:0] FMT_I2 = 3'd2;
    localparam logic [FMT_W-1:0] FMT_R  = 3'd3;
    localparam logic [FMT_W-1:0] FMT_SP = 3'd4;
    localparam logic [FMT_W-1:0] FMT_IL = 3'd7;

    // Width of the opcode the decode table is defined over
    localparam int OP_BASE_W = 5;

    localparam int REG_W  = 3;
    localparam int RS_LSB = 8;
    localparam int RT_LSB = 5;
    localparam int RD_LSB = 2;

    localparam int IMM_I1_W = 5;
    localparam int IMM_I2_W = 8;
    localparam int IMM_J_W  = 11;

endpackage

`default_nettype wire

// File: rtl/fmt_decode_q_lut.sv
// ============================================================================
//  Module      : fmt_decode_q_lut
//  Description : Combinational opcode-to-format table with immediate select.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmt_decode_q_lut
    import fmt_decode_q_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 5
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [FMT_W-1:0]   fmt,
    output logic [INSTR_W-1:0] imm
);

    logic [OP_W-1:0]      w_op;
    logic [OP_BASE_W-1:0] w_op_lo;
    logic                 w_op_hi_set;

    assign w_op    = instr[INSTR_W-1 -: OP_W];
    assign w_op_lo = w_op[OP_BASE_W-1:0];

    // Opcode bits above the table width must be zero for a legal encoding
    generate
        if (OP_W > OP_BASE_W) begin : g_wide_op
            assign w_op_hi_set = |w_op[OP_W-1:OP_BASE_W];
        end else begin : g_base_op
            assign w_op_hi_set = 1'b0;
        end
    endgenerate

    always_comb begin
        fmt = FMT_IL;
        if (!w_op_hi_set) begin
            casez (w_op_lo)
                5'b000??: fmt = FMT_SP;
                5'b001?0: fmt = FMT_J;
                5'b011??: fmt = FMT_I2;
                5'b001?1: fmt = FMT_I2;
                5'b11000: fmt = FMT_I2;
                5'b10010: fmt = FMT_I2;
                5'b010??: fmt = FMT_I1;
                5'b101??: fmt = FMT_I1;
                5'b1000?: fmt = FMT_I1;
                5'b10011: fmt = FMT_I1;
                5'b11001: fmt = FMT_R;
                5'b1101?: fmt = FMT_R;
                5'b111??: fmt = FMT_R;
                default:  fmt = FMT_IL;
            endcase
        end
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I1:  imm = {{(INSTR_W-IMM_I1_W){instr[IMM_I1_W-1]}}, instr[IMM_I1_W-1:0]};
            FMT_I2:  imm = {{(INSTR_W-IMM_I2_W){instr[IMM_I2_W-1]}}, instr[IMM_I2_W-1:0]};
            FMT_J:   imm = {{(INSTR_W-IMM_J_W){instr[IMM_J_W-1]}}, instr[IMM_J_W-1:0]};
            default: imm = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fmt_decode_q.sv
// ============================================================================
//  Module      : fmt_decode_q
//  Description : Decodes instruction words at push and queues the decoded
//                entries in a small FIFO toward the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmt_decode_q
    import fmt_decode_q_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 5,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FMT_W-1:0]   out_fmt,
    output logic [INSTR_W-1:0] out_instr,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [REG_W-1:0]   out_rd,
    output logic [INSTR_W-1:0] out_imm,
    output logic               out_ill,
    output logic [CNT_W-1:0]   ill_cnt
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w+1)'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w+1)'(1);

    logic [FMT_W-1:0]   w_fmt;
    logic [INSTR_W-1:0] w_imm;
    logic               w_push;
    logic               w_pop;

    logic [FMT_W-1:0]   r_fmt_mem   [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [INSTR_W-1:0] r_imm_mem   [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [CNT_W-1:0]   r_ill_cnt;

    fmt_decode_q_lut #(
        .INSTR_W (INSTR_W),
        .OP_W    (OP_W)
    ) u_lut (
        .instr (instr),
        .fmt   (w_fmt),
        .imm   (w_imm)
    );

    // Handshake flags come only from registered occupancy
    assign in_ready  = (r_count != c_full);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fmt_mem[i]   <= '0;
                r_instr_mem[i] <= '0;
                r_imm_mem[i]   <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fmt_mem[r_wr_ptr]   <= w_fmt;
                r_instr_mem[r_wr_ptr] <= instr;
                r_imm_mem[r_wr_ptr]   <= w_imm;
                r_wr_ptr              <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Debug counter survives flushes; it only clears on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ill_cnt <= '0;
        end else if (w_push && (w_fmt == FMT_IL) && (r_ill_cnt != {CNT_W{1'b1}})) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    assign out_fmt   = r_fmt_mem[r_rd_ptr];
    assign out_instr = r_instr_mem[r_rd_ptr];
    assign out_imm   = r_imm_mem[r_rd_ptr];
    assign out_rs    = out_instr[RS_LSB +: REG_W];
    assign out_rt    = out_instr[RT_LSB +: REG_W];
    assign out_rd    = out_instr[RD_LSB +: REG_W];
    assign out_ill   = (out_fmt == FMT_IL);
    assign ill_cnt   = r_ill_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fmt_decode_q.sv
// ============================================================================
//  Module      : tb_fmt_decode_q
//  Description : Self-checking bench for fmt_decode_q, 5-bit and 6-bit opcode
//                builds driven side by side against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmt_decode_q;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  fmt;
        logic [15:0] imm;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] instr;

    logic        in_ready_v  [2];
    logic        out_valid_v [2];
    logic        out_ill_v   [2];
    logic [2:0]  out_fmt_v   [2];
    logic [15:0] out_instr_v [2];
    logic [15:0] out_imm_v   [2];
    logic [2:0]  out_rs_v    [2];
    logic [2:0]  out_rt_v    [2];
    logic [2:0]  out_rd_v    [2];
    logic [7:0]  ill_cnt_v   [2];

    ent_t q0[$];
    ent_t q1[$];
    int   icnt0 = 0;
    int   icnt1 = 0;
    int   tests = 0;
    int   fails = 0;

    string pats [11] = '{"000xx", "001x0", "011xx", "001x1", "11000", "10010",
                         "010xx", "101xx", "1000x", "10011", "11xxx"};
    int    pfmt [11] = '{4, 0, 2, 2, 2, 2, 1, 1, 1, 1, 3};

    always #5 clk = ~clk;

    fmt_decode_q u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_v[0]),
        .instr     (instr),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready),
        .out_fmt   (out_fmt_v[0]),
        .out_instr (out_instr_v[0]),
        .out_rs    (out_rs_v[0]),
        .out_rt    (out_rt_v[0]),
        .out_rd    (out_rd_v[0]),
        .out_imm   (out_imm_v[0]),
        .out_ill   (out_ill_v[0]),
        .ill_cnt   (ill_cnt_v[0])
    );

    fmt_decode_q #(.OP_W(6)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_v[1]),
        .instr     (instr),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready),
        .out_fmt   (out_fmt_v[1]),
        .out_instr (out_instr_v[1]),
        .out_rs    (out_rs_v[1]),
        .out_rt    (out_rt_v[1]),
        .out_rd    (out_rd_v[1]),
        .out_imm   (out_imm_v[1]),
        .out_ill   (out_ill_v[1]),
        .ill_cnt   (ill_cnt_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Format from the opcode pattern list, first matching pattern wins
    function automatic int ref_fmt(input logic [15:0] ins, input int opw);
        int  op;
        int  b;
        bit  hit;
        byte ch;
        op = int'(ins) >> (16 - opw);
        if (op >= 32) return 7;
        for (int p = 0; p < 11; p++) begin
            hit = 1'b1;
            for (int c = 0; c < 5; c++) begin
                b  = (op >> (4 - c)) & 1;
                ch = pats[p][c];
                if (ch == "0" && b != 0) hit = 1'b0;
                if (ch == "1" && b != 1) hit = 1'b0;
            end
            if (hit) return pfmt[p];
        end
        return 7;
    endfunction

    function automatic logic [15:0] sext(input int v, input int bits);
        int x;
        x = v & ((1 << bits) - 1);
        if (x >= (1 << (bits - 1))) x = x - (1 << bits);
        return 16'(x);
    endfunction

    function automatic ent_t mk(input logic [15:0] ins, input int opw);
        ent_t e;
        e.instr = ins;
        e.fmt   = 3'(ref_fmt(ins, opw));
        case (e.fmt)
            3'd1:    e.imm = sext(int'(ins), 5);
            3'd2:    e.imm = sext(int'(ins), 8);
            3'd0:    e.imm = sext(int'(ins), 11);
            default: e.imm = 16'h0;
        endcase
        return e;
    endfunction

    task automatic check_dut(input int d, input int qsize, input ent_t h, input int icnt);
        chk($sformatf("dut%0d out_valid", d), 32'(out_valid_v[d]), 32'(qsize != 0));
        chk($sformatf("dut%0d in_ready", d), 32'(in_ready_v[d]), 32'(qsize < 2));
        chk($sformatf("dut%0d ill_cnt", d), 32'(ill_cnt_v[d]), 32'(icnt));
        if (qsize != 0) begin
            chk($sformatf("dut%0d out_fmt", d), 32'(out_fmt_v[d]), 32'(h.fmt));
            chk($sformatf("dut%0d out_instr", d), 32'(out_instr_v[d]), 32'(h.instr));
            chk($sformatf("dut%0d out_imm", d), 32'(out_imm_v[d]), 32'(h.imm));
            chk($sformatf("dut%0d out_rs", d), 32'(out_rs_v[d]), (32'(h.instr) >> 8) & 7);
            chk($sformatf("dut%0d out_rt", d), 32'(out_rt_v[d]), (32'(h.instr) >> 5) & 7);
            chk($sformatf("dut%0d out_rd", d), 32'(out_rd_v[d]), (32'(h.instr) >> 2) & 7);
            chk($sformatf("dut%0d out_ill", d), 32'(out_ill_v[d]), 32'(h.fmt == 3'd7));
        end
    endtask

    // One clock: drive, check at negedge, advance the model at posedge
    task automatic step(input logic v, input logic [15:0] ins, input logic rdy, input logic fl);
        ent_t e0;
        ent_t e1;
        ent_t blank;
        bit   push;
        bit   pop;
        int   sz;
        blank    = '{instr: 16'h0, fmt: 3'h0, imm: 16'h0};
        in_valid = v;
        instr    = ins;
        out_ready = rdy;
        flush    = fl;
        @(negedge clk);
        check_dut(0, q0.size(), (q0.size() != 0) ? q0[0] : blank, icnt0);
        check_dut(1, q1.size(), (q1.size() != 0) ? q1[0] : blank, icnt1);
        @(posedge clk);
        sz   = q0.size();
        push = v && (sz < 2) && !fl;
        pop  = (sz != 0) && rdy && !fl;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            icnt0 = 0;
            icnt1 = 0;
        end else if (fl) begin
            q0.delete();
            q1.delete();
        end else begin
            if (pop) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (push) begin
                e0 = mk(ins, 5);
                e1 = mk(ins, 6);
                q0.push_back(e0);
                q1.push_back(e1);
                if (e0.fmt == 3'd7 && icnt0 < 255) icnt0++;
                if (e1.fmt == 3'd7 && icnt1 < 255) icnt1++;
            end
        end
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset out_valid", 32'(out_valid_v[d]), 32'd0);
            chk("reset in_ready", 32'(in_ready_v[d]), 32'd1);
            chk("reset ill_cnt", 32'(ill_cnt_v[d]), 32'd0);
            chk("reset out_fmt", 32'(out_fmt_v[d]), 32'd0);
            chk("reset out_instr", 32'(out_instr_v[d]), 32'd0);
            chk("reset out_imm", 32'(out_imm_v[d]), 32'd0);
        end

        // First push visible one cycle later
        step(1'b1, 16'h4000, 1'b1, 1'b0);
        chk("first out_valid", 32'(out_valid_v[0]), 32'd1);
        chk("first out_fmt", 32'(out_fmt_v[0]), 32'd1);
        chk("first out_imm", 32'(out_imm_v[0]), 32'd0);

        // Opcode sweep at full throughput
        for (int op = 0; op < 32; op++) begin
            step(1'b1, {5'(op), 11'($urandom)}, 1'b1, 1'b0);
            if (op == 17) chk("op10001 fmt", 32'(out_fmt_v[0]), 32'd1);
        end
        chk("sweep ill_cnt", 32'(ill_cnt_v[0]), 32'd0);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Backpressure with a full queue, then release in order
        step(1'b1, 16'h5AA1, 1'b0, 1'b0);
        step(1'b1, 16'hC3B2, 1'b0, 1'b0);
        chk("full in_ready", 32'(in_ready_v[0]), 32'd0);
        step(1'b1, 16'h9C47, 1'b0, 1'b0);
        step(1'b1, 16'h9C47, 1'b1, 1'b0);
        chk("release head B", 32'(out_instr_v[0]), 32'hC3B2);
        step(1'b1, 16'h9C47, 1'b1, 1'b0);
        chk("release head C", 32'(out_instr_v[0]), 32'h9C47);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Immediate sign extension
        step(1'b1, 16'h27FF, 1'b1, 1'b0);
        chk("J imm", 32'(out_imm_v[0]), 32'hFFFF);
        chk("J fmt", 32'(out_fmt_v[0]), 32'd0);
        step(1'b1, 16'h4810, 1'b1, 1'b0);
        chk("I1 imm", 32'(out_imm_v[0]), 32'hFFF0);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Flush drops queue and the same-cycle push
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 16'h5678, 1'b0, 1'b0);
        step(1'b1, 16'h9ABC, 1'b0, 1'b1);
        chk("flush out_valid", 32'(out_valid_v[0]), 32'd0);
        chk("flush in_ready", 32'(in_ready_v[0]), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b0);

        // Illegal opcode saturation on the 6-bit build
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 16'h8000 | 16'($urandom_range(0, 1023)), 1'b1, 1'b0);
            chk("wide out_ill", 32'(out_ill_v[1]), 32'd1);
        end
        chk("wide ill_cnt sat", 32'(ill_cnt_v[1]), 32'd255);
        chk("narrow ill_cnt", 32'(ill_cnt_v[0]), 32'd0);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 600; i++) begin
            rst_n = (i == 300) ? 1'b0 : 1'b1;
            step(1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
